// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
//   NOP_INSTR        : canonical NOP (addi x0,x0,0), used as the reset/fault instruction.
//   DEFAULT_RESET_PC : default byte address of the first fetch.
//   fetch_state_t    : fetch FSM states.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with valid/ready handshake and flush.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture in_* this edge (caller guarantees slot is free)
//   flush               : drop the held bundle (priority over load)
//   in_pc/instr/fault   : bundle to capture
//   out_ready           : downstream accepts the held bundle
//   out_valid/pc/instr/fault : held bundle
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        in_fault,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (flush) begin
      // Fields are left untouched so they stay stable while invalid.
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
      fault_d = in_fault;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_fault = fault_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetch FSM, drives the word-indexed
// instruction memory address and captures read data into the IF/ID register.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   fetch_en                        : permits new fetches
//   redirect_valid/redirect_target  : taken branch/jump, byte target (bits [1:0] ignored)
//   imem_addr  (out)                : word index {2'b00, pc[31:2]}
//   imem_instr (in)                 : combinational read data for imem_addr
//   out_valid/out_ready             : IF/ID handshake
//   out_pc/out_instr/out_fault      : IF/ID bundle; fault marks an out-of-range word
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_DEPTH = 65
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         adv;
  logic         capture;
  logic         fault;
  logic [31:0]  cap_instr;

  assign imem_addr = {2'b00, pc_q[31:2]};
  assign fault     = (imem_addr >= IMEM_DEPTH);
  assign cap_instr = fault ? NOP_INSTR : imem_instr;

  assign adv     = (state_q == RUN) && (!out_valid || out_ready);
  // Leaving RUN (fetch_en low) suppresses capture on that edge.
  assign capture = adv && fetch_en && !redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_target & 32'hFFFF_FFFC;
    end else if (capture) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .RESET_PC(RESET_PC)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .flush    (redirect_valid),
    .in_pc    (pc_q),
    .in_instr (cap_instr),
    .in_fault (fault),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_fault(out_fault)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory model: word i < 65 holds C0DE_<i>; beyond that the bus returns junk.
  always_comb begin
    if (imem_addr < 32'd65) imem_instr = {16'hC0DE, imem_addr[15:0]};
    else                    imem_instr = 32'hDEAD_BEEF;
  end

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(65)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=00000000", out_pc); end
    total++; if (out_instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr got=%h exp=00000013", out_instr); end
    total++; if (out_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", out_fault); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_imem got=%h exp=00000000", imem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    fetch_en = 1'b1;
  endtask

  task automatic test_stream();
    tick(); // edge 1: IDLE->RUN, nothing captured
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_edge1_valid got=%b exp=0", out_valid); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL stream_edge1_imem got=%h exp=0", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_pc !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 32'(i * 4)); end
      total++; if (out_instr !== {16'hC0DE, 16'(i)}) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, {16'hC0DE, 16'(i)}); end
      total++; if (imem_addr !== 32'(i + 1)) begin bad++; $display("FAIL stream_imem[%0d] got=%h exp=%h", i, imem_addr, 32'(i + 1)); end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_pc !== 32'h8) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=00000008", i, out_pc); end
      total++; if (out_instr !== 32'hC0DE_0002) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=c0de0002", i, out_instr); end
      total++; if (imem_addr !== 32'h3) begin bad++; $display("FAIL stall_imem[%0d] got=%h exp=3", i, imem_addr); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_pc !== 32'hC) begin bad++; $display("FAIL stall_resume_pc got=%h exp=0000000c", out_pc); end
    total++; if (out_instr !== 32'hC0DE_0003) begin bad++; $display("FAIL stall_resume_instr got=%h exp=c0de0003", out_instr); end
    tick();
    total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL stall_next_pc got=%h exp=00000010", out_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin bad++; $display("FAIL redir_pre got=%b/%h exp=1/00000004", out_valid, out_pc); end
    redirect_valid = 1'b1; redirect_target = 32'h0000_0012;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", out_valid); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL redir_imem got=%h exp=4", imem_addr); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%b exp=1", out_valid); end
    total++; if (out_pc !== 32'h10) begin bad++; $display("FAIL redir_pc got=%h exp=00000010", out_pc); end
    total++; if (out_instr !== 32'hC0DE_0004) begin bad++; $display("FAIL redir_instr got=%h exp=c0de0004", out_instr); end
    total++; if (imem_addr !== 32'h5) begin bad++; $display("FAIL redir_imem_next got=%h exp=5", imem_addr); end
  endtask

  task automatic test_fault();
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    logic        exp_f  [4];
    exp_pc = '{32'hF8, 32'hFC, 32'h100, 32'h104};
    exp_in = '{32'hC0DE_003E, 32'hC0DE_003F, 32'hC0DE_0040, 32'h0000_0013};
    exp_f  = '{1'b0, 1'b0, 1'b0, 1'b1};
    redirect_valid = 1'b1; redirect_target = 32'h0000_00F8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_pc !== exp_pc[i]) begin bad++; $display("FAIL fault_pc[%0d] got=%h exp=%h", i, out_pc, exp_pc[i]); end
      total++; if (out_instr !== exp_in[i]) begin bad++; $display("FAIL fault_instr[%0d] got=%h exp=%h", i, out_instr, exp_in[i]); end
      total++; if (out_fault !== exp_f[i]) begin bad++; $display("FAIL fault_flag[%0d] got=%b exp=%b", i, out_fault, exp_f[i]); end
    end
    // Wrap at top of the address space: low bits of target are dropped.
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 32'h3FFF_FFFF) begin bad++; $display("FAIL wrap_imem_top got=%h exp=3fffffff", imem_addr); end
    tick();
    total++; if (out_pc !== 32'hFFFF_FFFC || out_fault !== 1'b1) begin bad++; $display("FAIL wrap_top got=%h/%b exp=fffffffc/1", out_pc, out_fault); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_imem got=%h exp=0", imem_addr); end
    tick();
    total++; if (out_pc !== 32'h0 || out_instr !== 32'hC0DE_0000 || out_fault !== 1'b0) begin bad++; $display("FAIL wrap_zero got=%h/%h/%b exp=0/c0de0000/0", out_pc, out_instr, out_fault); end
  endtask

  task automatic test_drop_en();
    // Bundle pc 0 is held, internal pc is 4.
    out_ready = 1'b0; fetch_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin bad++; $display("FAIL drop_hold[%0d] got=%b/%h exp=1/0", i, out_valid, out_pc); end
      total++; if (imem_addr !== 32'h1) begin bad++; $display("FAIL drop_imem[%0d] got=%h exp=1", i, imem_addr); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drop_empty[%0d] got=%b exp=0", i, out_valid); end
      total++; if (imem_addr !== 32'h1) begin bad++; $display("FAIL drop_pc[%0d] got=%h exp=1", i, imem_addr); end
    end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin bad++; $display("FAIL areset_pre got=%b/%h exp=1/00000004", out_valid, out_pc); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got=%b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL areset_pc got=%h exp=0", out_pc); end
    total++; if (out_instr !== 32'h0000_0013) begin bad++; $display("FAIL areset_instr got=%h exp=00000013", out_instr); end
    total++; if (out_fault !== 1'b0) begin bad++; $display("FAIL areset_fault got=%b exp=0", out_fault); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL areset_imem got=%h exp=0", imem_addr); end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_fault();
    test_drop_en();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
